gf2_mat_vec_seq: RTL and testbench
==================================

GF2_MAT_VEC_SEQ -- requirements
Module: gf2_mat_vec_seq

Interface
REQ-001 Parameter A_ROWS, default 4: rows of matrix A (= C length).
REQ-002 Parameter A_COLS, default 8: columns of A (= B column length).
REQ-003 Parameter LANES, default 1: output rows computed per cycle; SHALL divide A_ROWS evenly.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 a_load  input  1  pulse: capture A_data_in into the internal matrix register.
REQ-007 A_data_in  input  A_ROWS*A_COLS  matrix; element A[r][k] at bit r*A_COLS+k.
REQ-008 in_valid  input  1  B_data_in valid.
REQ-009 in_ready  output  1  block accepts a column this cycle.
REQ-010 B_data_in  input  A_COLS  column vector; element B[k] at bit k.
REQ-011 out_valid  output  1  C_data_out valid.
REQ-012 out_ready  input  1  consumer accepts C_data_out.
REQ-013 C_data_out  output  A_ROWS  result; C[r] at bit r.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Arithmetic SHALL be GF(2): C[r] = XOR over k of (A[r][k] AND B[k]); no carries, no widening.
REQ-016 FSM states: IDLE, COMPUTE, DONE.
REQ-017 IDLE: in_ready = !a_load; a column is accepted when in_valid && in_ready; on accept, B latches, row counter clears, state -> COMPUTE.
REQ-018 COMPUTE: LANES rows of C written per cycle, row counter advancing by LANES; after N = A_ROWS/LANES cycles, state -> DONE.
REQ-019 DONE: out_valid = 1; C_data_out SHALL hold stable until out_valid && out_ready, then state -> IDLE.
REQ-020 Latency: with acceptance at edge T, out_valid SHALL rise at edge T+N and not earlier.
REQ-021 in_ready SHALL be 0 in COMPUTE and DONE; in_valid there is ignored.
REQ-022 a_load SHALL take effect only in IDLE; in COMPUTE/DONE it is ignored and the stored A is unchanged.
REQ-023 a_load and in_valid in the same IDLE cycle: A loads, no column is accepted (in_ready = 0).
REQ-024 Stored A SHALL persist across any number of columns until the next accepted a_load or reset.
REQ-025 C_data_out SHALL retain its last value outside DONE; rows not yet computed in COMPUTE are not required to be meaningful.
REQ-026 out_ready held high in DONE: one-cycle out_valid pulse, IDLE next cycle; throughput one column per N+2 cycles.

Reset
REQ-027 While rst = 0: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, C_data_out = 0, stored A = 0, B register = 0, row counter = 0.
REQ-028 Reset asserted mid-COMPUTE or mid-DONE SHALL abort immediately; the pending result is discarded and never presented.
REQ-029 After rst deasserts, the first rising edge SHALL behave as IDLE.

Structure
REQ-030 Shared package gf2_mm_pkg SHALL hold the FSM state enum typedef and a function computing the row-counter width from A_ROWS.
REQ-031 Sub-module gf2_dot_row (A_COLS-bit AND then XOR-reduce, purely combinational) SHALL be instantiated LANES times.
REQ-032 Parameter check: A_ROWS % LANES != 0 SHALL cause an elaboration error.

Verification (A_ROWS=4, A_COLS=8)
REQ-033 LANES=1, a_load with A=32'h08040201, then B=8'h0B -> C_data_out=4'hB, out_valid 4 cycles after acceptance.
REQ-034 A=32'hFFFFFFFF, B=8'h07 -> C=4'hF; then B=8'h03 without reload -> C=4'h0.
REQ-035 LANES=4, same as REQ-033 -> C=4'hB, out_valid 1 cycle after acceptance.
REQ-036 out_ready low 5 cycles in DONE -> C_data_out and out_valid stable, in_ready=0; out_ready high -> IDLE next cycle.
REQ-037 a_load with A=32'h0 during COMPUTE -> ignored, result matches previously stored A; a_load+in_valid in IDLE -> A loaded, column not accepted.
REQ-038 rst low 2nd cycle of COMPUTE -> outputs at reset values, no out_valid after release, next column computes with A=0 -> C=4'h0.

Source files
------------

// File: rtl/gf2_mm_pkg.sv
// Shared types for the GF(2) matrix-vector engine: FSM state encoding and
// the row-counter width helper.
package gf2_mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic int row_cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/gf2_dot_row.sv
// GF(2) inner product of one matrix row with the column vector.
// Purely combinational: AND the operands, then XOR-reduce.
module gf2_dot_row #(
  parameter int A_COLS = 8
) (
  input  logic [A_COLS-1:0] a_row,
  input  logic [A_COLS-1:0] b_vec,
  output logic              dot
);

  assign dot = ^(a_row & b_vec);

endmodule

// File: rtl/gf2_mat_vec_seq.sv
// Sequential GF(2) C = A*B: LANES rows per cycle, out_valid A_ROWS/LANES edges after accept.
// Single column in flight; in_ready low while computing or holding a result until out_ready.
module gf2_mat_vec_seq
  import gf2_mm_pkg::*;
#(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 8,
  parameter int LANES  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_load,
  input  logic [A_ROWS*A_COLS-1:0] A_data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_COLS-1:0]        B_data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [A_ROWS-1:0]        C_data_out,
  output logic                     busy
);

  if ((A_ROWS % LANES) != 0) begin : g_bad_lanes
    $error("gf2_mat_vec_seq: LANES must divide A_ROWS evenly");
  end

  localparam int            CW       = row_cnt_w(A_ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(A_ROWS - LANES);
  localparam logic [CW-1:0] STEP     = CW'(LANES);

  state_e                          state_q, state_d;
  logic [A_ROWS-1:0][A_COLS-1:0]   a_q, a_d;
  logic [A_COLS-1:0]               b_q, b_d;
  logic [CW-1:0]                   row_cnt_q, row_cnt_d;
  logic [A_ROWS-1:0]               c_q, c_d;
  logic [LANES-1:0]                lane_c;
  logic [CW-1:0]                   lane_row [LANES];

  // Lane l handles row row_cnt_q + l; row_cnt_q only takes multiples of LANES.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_row[l] = row_cnt_q + CW'(l);

    gf2_dot_row #(
      .A_COLS(A_COLS)
    ) u_dot (
      .a_row(a_q[lane_row[l]]),
      .b_vec(b_q),
      .dot  (lane_c[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    row_cnt_d = row_cnt_q;
    c_d       = c_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A load wins over a column offered in the same cycle.
        in_ready = !a_load;
        if (a_load) begin
          a_d = A_data_in;
        end else if (in_valid) begin
          b_d       = B_data_in;
          row_cnt_d = '0;
          state_d   = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        for (int l = 0; l < LANES; l++) begin
          c_d[lane_row[l]] = lane_c[l];
        end
        if (row_cnt_q == LAST_ROW) begin
          state_d = ST_DONE;
        end else begin
          row_cnt_d = row_cnt_q + STEP;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      row_cnt_q <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      row_cnt_q <= row_cnt_d;
      c_q       <= c_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign C_data_out = c_q;

endmodule

// File: tb/tb_gf2_mat_vec_seq.sv
// Scoreboard bench for gf2_mat_vec_seq: randomized columns against a parity-sum model,
// plus a LANES=4 instance for single-cycle latency.
module tb_gf2_mat_vec_seq;

  localparam int A_ROWS = 4;
  localparam int A_COLS = 8;
  localparam int LANES  = 1;
  localparam int NCYC   = A_ROWS / LANES;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_load;
  logic [31:0] A_data_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  B_data_in;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  C_data_out;
  logic        busy;

  logic        a_load4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  c4;

  gf2_mat_vec_seq #(.A_ROWS(A_ROWS), .A_COLS(A_COLS), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .a_load(a_load), .A_data_in(A_data_in),
    .in_valid(in_valid), .in_ready(in_ready), .B_data_in(B_data_in),
    .out_valid(out_valid), .out_ready(out_ready), .C_data_out(C_data_out), .busy(busy)
  );

  gf2_mat_vec_seq #(.A_ROWS(A_ROWS), .A_COLS(A_COLS), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .a_load(a_load4), .A_data_in(A_data_in),
    .in_valid(in_valid4), .in_ready(in_ready4), .B_data_in(B_data_in),
    .out_valid(out_valid4), .out_ready(out_ready4), .C_data_out(c4), .busy(busy4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] c;
    int         acc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // C[r] = parity of the count of k where A[r][k] and B[k] are both 1.
  function automatic logic [3:0] model(input logic [31:0] a, input logic [7:0] b);
    logic [3:0] c;
    int s;
    c = '0;
    for (int r = 0; r < A_ROWS; r++) begin
      s = 0;
      for (int k = 0; k < A_COLS; k++) begin
        if (a[r*A_COLS+k] && b[k]) s++;
      end
      c[r] = (s % 2) == 1;
    end
    return c;
  endfunction

  logic       vld_prev = 1'b0;
  logic       hs_prev  = 1'b0;
  logic [3:0] c_prev   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_c", 32'(C_data_out), 32'd0);
      chk("rst4_out_valid", 32'(out_valid4), 32'd0);
      chk("rst4_c", 32'(c4), 32'd0);
      vld_prev = 1'b0;
      hs_prev  = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("idle_after_hs_busy", 32'(busy), 32'd0);
        chk("idle_after_hs_vld", 32'(out_valid), 32'd0);
      end
      if (out_valid) begin
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        if (!vld_prev) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got out_valid=1 C=%0h, expected no pending result",
                     C_data_out);
          end else begin
            chk("result_c", 32'(C_data_out), 32'(sb[0].c));
            chk("latency", cyc - sb[0].acc, NCYC);
          end
        end else begin
          chk("hold_c", 32'(C_data_out), 32'(c_prev));
        end
        if (out_ready) begin
          if (sb.size() > 0) void'(sb.pop_front());
          done_cnt++;
        end
      end
      vld_prev = out_valid && !out_ready;
      hs_prev  = out_valid && out_ready;
      c_prev   = C_data_out;
    end
  end

  // One column: optional A load (optionally with a colliding in_valid), the column
  // itself, then junk a_load/in_valid traffic until the result is taken.
  task automatic run_col(input logic [31:0] a_new, input bit do_load, input bit load_vld,
                         input logic [7:0] b, input int hold);
    int start_done;
    int k;
    if (do_load) begin
      @(posedge clk); #1;
      a_load    = 1'b1;
      A_data_in = a_new;
      in_valid  = load_vld;
      B_data_in = 8'($urandom);
      @(negedge clk);
      chk("load_blocks_ready", 32'(in_ready), 32'd0);
      model_a = a_new;
    end
    @(posedge clk); #1;
    a_load    = 1'b0;
    in_valid  = 1'b1;
    B_data_in = b;
    @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    sb.push_back('{c: model(model_a, b), acc: cyc + 1});
    start_done = done_cnt;
    k = 0;
    while (k < 60) begin
      @(posedge clk); #1;
      if (done_cnt != start_done) break;
      a_load    = 1'($urandom % 2);
      A_data_in = ($urandom % 2 == 0) ? 32'h0 : $urandom;
      in_valid  = 1'($urandom % 2);
      B_data_in = 8'($urandom);
      out_ready = (k >= hold) ? 1'($urandom % 2) : 1'b0;
      k++;
    end
    a_load   = 1'b0;
    in_valid = 1'b0;
    if (done_cnt == start_done) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got no handshake in 60 cycles, expected one result");
    end
  endtask

  task automatic reset_mid_compute();
    @(posedge clk); #1;
    a_load    = 1'b0;
    in_valid  = 1'b1;
    B_data_in = 8'($urandom);
    @(negedge clk);
    chk("accept_ready_rst", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b0;
    model_a = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    run_col(32'h0, 1'b0, 1'b0, 8'($urandom | 1), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    a_load     = 1'b0;
    A_data_in  = '0;
    in_valid   = 1'b0;
    B_data_in  = '0;
    out_ready  = 1'b0;
    a_load4    = 1'b0;
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    model_a    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_col(32'h08040201, 1'b1, 1'b0, 8'h0B, 0);
    run_col(32'hFFFFFFFF, 1'b1, 1'b1, 8'h07, 10);
    run_col(32'h0, 1'b0, 1'b0, 8'h03, 0);
    for (int i = 0; i < 120; i++) begin
      run_col($urandom, ($urandom % 3) == 0, 1'($urandom % 2), 8'($urandom),
              ($urandom % 4 == 0) ? 10 : 0);
    end
    reset_mid_compute();

    // LANES=4 instance: whole result in one compute cycle.
    @(posedge clk); #1;
    a_load4   = 1'b1;
    A_data_in = 32'h08040201;
    @(posedge clk); #1;
    a_load4   = 1'b0;
    in_valid4 = 1'b1;
    B_data_in = 8'h0B;
    @(negedge clk);
    chk("l4_accept_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("l4_not_early", 32'(out_valid4), 32'd0);
    chk("l4_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    chk("l4_valid", 32'(out_valid4), 32'd1);
    chk("l4_c", 32'(c4), 32'(model(32'h08040201, 8'h0B)));
    @(negedge clk);
    chk("l4_idle_vld", 32'(out_valid4), 32'd0);
    chk("l4_idle_busy", 32'(busy4), 32'd0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover_results: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
